uart_tx_fifo: RTL and testbench

//  Parametrised UART transmitter with a FIFO front end and runtime frame config.
//  - Accepts words over valid/ready into a FIFO and serialises each frame LSB-first:

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_fifo_if.sv | 21 ++
 rtl/sync_fifo.sv | 49 ++++
 rtl/uart_tx_fifo.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART datapath.
// Used by the transmit path and the FIFO-based front end.
package uart_pkg;

  localparam int DEFAULT_CLK_PER_BIT = 868;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // 01 selects even, 10 odd, the other codes no parity
  function automatic parity_e par_decode(input logic [1:0] cfg);
    case (cfg)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Valid/ready word handshake into the UART transmit FIFO.
// The producer drives valid/data, the UART returns ready.
interface uart_tx_fifo_if #(
  parameter int PACK_SIZE = 8
);
  logic                 tx_valid;
  logic                 tx_ready;
  logic [PACK_SIZE-1:0] tx_data;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read.
// A write while full is dropped, even alongside a read.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             wr;
  logic             rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign rdata = mem[rptr];

  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a word FIFO.
// Config is latched per frame at the pop.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int PACK_SIZE   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_W       = 16,
  localparam int CW = $clog2(FIFO_DEPTH) + 1,
  localparam int IW = $clog2(PACK_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_fifo_if.slave    tx,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  output logic             tx_bit,
  output logic             tx_active,
  output logic             tx_done,
  output logic [CW-1:0]    fifo_count
);

  tx_state_e            state, state_n;
  logic [DIV_W-1:0]     cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic                 stop_sec, stop_sec_n;
  logic                 line_n;
  logic                 pop;
  logic                 done;
  logic                 last;
  logic                 full;
  logic                 empty;
  logic [PACK_SIZE-1:0] rdata;
  logic [PACK_SIZE-1:0] data_q;
  logic [DIV_W-1:0]     div_q;
  logic [DIV_W-1:0]     div_eff;
  parity_e              par_q;
  logic                 par_bit;
  logic                 stop2_q;

  sync_fifo #(
    .WIDTH (PACK_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx.tx_valid),
    .pop   (pop),
    .wdata (tx.tx_data),
    .rdata (rdata),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  assign tx.tx_ready = !full;
  assign div_eff     = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
  assign last        = (cnt == div_q - DIV_W'(1));
  assign tx_active   = (state != IDLE);
  assign tx_done     = done;

  // next bit, next state, and the pop that starts a frame
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    stop_sec_n = stop_sec;
    line_n     = tx_bit;
    done       = 1'b0;
    pop        = 1'b0;
    unique case (state)
      IDLE: line_n = 1'b1;
      START: begin
        cnt_n = cnt + DIV_W'(1);
        if (last) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
          line_n  = data_q[0];
        end
      end
      DATA: begin
        cnt_n = cnt + DIV_W'(1);
        if (last) begin
          cnt_n = '0;
          if (idx == IW'(PACK_SIZE - 1)) begin
            if (par_q != PAR_NONE) begin
              state_n = PARITY;
              line_n  = par_bit;
            end else begin
              state_n    = STOP;
              stop_sec_n = 1'b0;
              line_n     = 1'b1;
            end
          end else begin
            idx_n  = idx + IW'(1);
            line_n = data_q[idx + IW'(1)];
          end
        end
      end
      PARITY: begin
        cnt_n = cnt + DIV_W'(1);
        if (last) begin
          cnt_n      = '0;
          state_n    = STOP;
          stop_sec_n = 1'b0;
          line_n     = 1'b1;
        end
      end
      STOP: begin
        cnt_n = cnt + DIV_W'(1);
        if (last) begin
          cnt_n  = '0;
          line_n = 1'b1;
          if (stop2_q && !stop_sec) begin
            stop_sec_n = 1'b1;
          end else begin
            done    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (!empty && (state == IDLE || done)) begin
      pop     = 1'b1;
      state_n = START;
      cnt_n   = '0;
      line_n  = 1'b0;
    end
  end

  // FSM state, counters and the registered line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      stop_sec <= 1'b0;
      tx_bit   <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      stop_sec <= stop_sec_n;
      tx_bit   <= line_n;
    end
  end

  // frame word and config captured once per frame at the pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      div_q   <= DIV_W'(CLK_PER_BIT);
      par_q   <= PAR_NONE;
      par_bit <= 1'b0;
      stop2_q <= 1'b0;
    end else if (pop) begin
      data_q  <= rdata;
      div_q   <= div_eff;
      par_q   <= par_decode(cfg_parity);
      par_bit <= (par_decode(cfg_parity) == PAR_ODD) ? ~^rdata : ^rdata;
      stop2_q <= cfg_stop2;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: waveform-queue model plus
// directed frame scenarios and a random traffic phase.
module tb_uart_tx_fifo;

  localparam int PS = 8;
  localparam int FD = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] cfg_div = 16'd10;
  logic [1:0]    cfg_parity = 2'b00;
  logic          cfg_stop2 = 1'b0;
  logic          tx_bit;
  logic          tx_active;
  logic          tx_done;
  logic [2:0]    fifo_count;

  int n_vec = 0;
  int n_err = 0;
  int maxc  = 0;

  uart_tx_fifo_if #(.PACK_SIZE(PS)) txi ();

  uart_tx_fifo #(
    .CLK_PER_BIT (10),
    .PACK_SIZE   (PS),
    .FIFO_DEPTH  (FD),
    .DIV_W       (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx         (txi),
    .cfg_div    (cfg_div),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .tx_bit     (tx_bit),
    .tx_active  (tx_active),
    .tx_done    (tx_done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model: queued words plus the remaining line waveform of the current frame
  logic [PS-1:0] mq [$];
  bit            wave [$];

  function automatic void build(input logic [PS-1:0] w);
    bit b [$];
    int d;
    d = (cfg_div < 2) ? 2 : int'(cfg_div);
    b.push_back(1'b0);
    for (int i = 0; i < PS; i++) b.push_back(w[i]);
    if (cfg_parity == 2'b01) b.push_back(^w);
    if (cfg_parity == 2'b10) b.push_back(~^w);
    b.push_back(1'b1);
    if (cfg_stop2) b.push_back(1'b1);
    foreach (b[i]) repeat (d) wave.push_back(b[i]);
  endfunction

  always @(negedge rst) begin
    mq.delete();
    wave.delete();
  end

  always @(posedge clk) begin : model
    bit lastc;
    bit cp;
    if (!rst) begin
      mq.delete();
      wave.delete();
    end else begin
      lastc = (wave.size() <= 1);
      cp    = txi.tx_valid && (mq.size() < FD);
      if (wave.size() > 0) void'(wave.pop_front());
      if (lastc && mq.size() > 0) build(mq.pop_front());
      if (cp) mq.push_back(txi.tx_data);
    end
    #1;
    chk("line", 32'(tx_bit), (wave.size() > 0) ? 32'(wave[0]) : 32'd1);
    chk("active", 32'(tx_active), 32'(wave.size() > 0));
    chk("done", 32'(tx_done), 32'(wave.size() == 1));
    chk("count", 32'(fifo_count), 32'(mq.size()));
    chk("ready", 32'(txi.tx_ready), 32'(mq.size() < FD));
    if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
  end

  task automatic push_word(input logic [PS-1:0] w);
    @(negedge clk);
    txi.tx_valid = 1'b1;
    txi.tx_data  = w;
    @(negedge clk);
    txi.tx_valid = 1'b0;
  endtask

  task automatic push_burst(input int n, input logic [PS-1:0] base);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      txi.tx_valid = 1'b1;
      txi.tx_data  = base + PS'(i);
      @(negedge clk);
    end
    txi.tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((tx_active || fifo_count != 0) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  // captures one frame; ends one cycle after tx_done
  task automatic capture(output logic [15:0] bits, output int len,
                         output int wt, input int d);
    int nb;
    bits = '0;
    len  = 0;
    wt   = 0;
    nb   = 0;
    while (!tx_active && wt < 3000) begin
      @(negedge clk);
      wt++;
    end
    if (!tx_active) begin
      chk("cap_start_timeout", 32'd0, 32'd1);
      return;
    end
    forever begin
      len++;
      if (((len - 1) % d) == d / 2 && nb < 16) begin
        bits[nb] = tx_bit;
        nb++;
      end
      if (tx_done) break;
      if (len >= 2000) begin
        chk("cap_done_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] bits;
    int len;
    int wt;
    txi.tx_valid = 1'b0;
    txi.tx_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_line", 32'(tx_bit), 32'd1);
    chk("rst_ready", 32'(txi.tx_ready), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // basic frame
    push_word(8'hA5);
    capture(bits, len, wt, 10);
    chk("t1_len", 32'(len), 32'd100);
    chk("t1_bits", 32'(bits[9:0]), 32'h34A);
    chk("t1_idle", 32'(tx_active), 32'd0);

    // even then odd parity
    cfg_parity = 2'b01;
    push_word(8'h07);
    capture(bits, len, wt, 10);
    chk("t2e_len", 32'(len), 32'd110);
    chk("t2e_data", 32'(bits[8:1]), 32'h07);
    chk("t2e_par", 32'(bits[9]), 32'd1);
    cfg_parity = 2'b10;
    push_word(8'h07);
    capture(bits, len, wt, 10);
    chk("t2o_len", 32'(len), 32'd110);
    chk("t2o_par", 32'(bits[9]), 32'd0);
    chk("t2o_stop", 32'(bits[10]), 32'd1);

    // back-to-back with two stop bits
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b1;
    fork
      push_burst(3, 8'h3C);
      capture(bits, len, wt, 10);
    join
    chk("t3_len0", 32'(len), 32'd110);
    for (int f = 1; f < 3; f++) begin
      capture(bits, len, wt, 10);
      chk("t3_len", 32'(len), 32'd110);
      chk("t3_gap", 32'(wt), 32'd0);
      chk("t3_data", 32'(bits[8:1]), 32'(8'h3C + f));
    end
    wait_idle();

    // overflow burst
    cfg_stop2 = 1'b0;
    maxc = 0;
    push_burst(6, 8'h50);
    chk("t4_full_ready", 32'(txi.tx_ready), 32'd0);
    chk("t4_full_count", 32'(fifo_count), 32'd4);
    wait_idle();
    chk("t4_max", 32'(maxc), 32'd4);

    // divider change mid-frame, then clamping
    fork
      push_burst(2, 8'h81);
      capture(bits, len, wt, 10);
      begin
        repeat (30) @(negedge clk);
        cfg_div = 16'd4;
      end
    join
    chk("t5_len_old", 32'(len), 32'd100);
    capture(bits, len, wt, 4);
    chk("t5_len_new", 32'(len), 32'd40);
    chk("t5_data", 32'(bits[8:1]), 32'h82);
    wait_idle();
    cfg_div = 16'd0;
    fork
      push_word(8'hC3);
      capture(bits, len, wt, 2);
    join
    chk("t5_len_min", 32'(len), 32'd20);
    chk("t5_data_min", 32'(bits[8:1]), 32'hC3);
    wait_idle();

    // reset in the middle of a frame
    cfg_div = 16'd10;
    push_burst(3, 8'h11);
    repeat (25) @(negedge clk);
    chk("t6_pre_active", 32'(tx_active), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_line", 32'(tx_bit), 32'd1);
    chk("t6_active", 32'(tx_active), 32'd0);
    chk("t6_count", 32'(fifo_count), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_idle", 32'(tx_active), 32'd0);

    // random traffic and config
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        cfg_div    = 16'($urandom_range(0, 6));
        cfg_parity = 2'($urandom);
        cfg_stop2  = 1'($urandom);
      end
      txi.tx_valid = ($urandom_range(0, 5) == 0);
      txi.tx_data  = PS'($urandom);
    end
    txi.tx_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
